pci_arbiter: RTL

Four-master round-robin PCI bus arbiter. Samples the masters' active-low request lines and the bus FRAME#/IRDY# signals, then selects one owner per transaction. It produces the 2-bit winner index, a grant-enable and a grant-kill strobe, which drive the grant decoder directly downstream. That decoder turns them into the four active-low GNT# lines. All arbitration state is registered; outputs change only on the clock edge.

---
 rtl/pci_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pci_arbiter.sv
// -----------------------------------------------------------------------------
// pci_arbiter
//
// Four-master round-robin PCI bus arbiter. Samples the active-low request
// lines together with FRAME#/IRDY#, picks one owner per transaction and drives
// the downstream grant decoder with an index, an enable and a kill strobe.
// Every output is a register, so the decoder sees glitch-free edges.
//
// Ports:
//   clk        bus clock, all logic on the rising edge
//   rst        synchronous, active-high reset
//   req_n      active-low requests, bit i = master i
//   frame_n    bus FRAME#, active low
//   irdy_n     bus IRDY#, active low
//   gnt_idx    index of the granted master (decoder IN)
//   gnt_en     high while a grant is driven (decoder enable)
//   gnt_kill   high forces every GNT# inactive; always the inverse of gnt_en
//   bus_busy   high while a granted transaction is in progress
//   bus_owner  master owning the current or most recent transaction
// -----------------------------------------------------------------------------
module pci_arbiter #(
    parameter int TIMEOUT = 16  // grant cycles allowed without FRAME#, 2..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_n,
    input  logic       frame_n,
    input  logic       irdy_n,
    output logic [1:0] gnt_idx,
    output logic       gnt_en,
    output logic       gnt_kill,
    output logic       bus_busy,
    output logic [1:0] bus_owner
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_TURN  = 2'd3;

    // tcnt holds the number of grant cycles already elapsed, so the grant is
    // revoked on the edge where this value is seen.
    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [1:0] ptr;
    logic [7:0] tcnt;

    logic [1:0] state_d;
    logic [1:0] ptr_d;
    logic [7:0] tcnt_d;
    logic [1:0] gnt_idx_d;
    logic [1:0] bus_owner_d;
    logic       gnt_en_d;
    logic       bus_busy_d;

    logic [3:0] req;
    logic       any_req;
    logic       bus_idle;
    logic [1:0] winner;
    logic [1:0] cand;

    assign req      = ~req_n;
    assign any_req  = |req;
    assign bus_idle = frame_n & irdy_n;

    // Round-robin search starting at ptr. Scanning the offsets from farthest
    // to nearest lets the nearest active request overwrite the others, so no
    // separate "found" flag is needed.
    always_comb begin
        winner = ptr;
        cand   = ptr;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        gnt_idx_d   = gnt_idx;
        bus_owner_d = bus_owner;
        gnt_en_d    = gnt_en;
        bus_busy_d  = bus_busy;
        tcnt_d      = (tcnt == 8'hFF) ? tcnt : tcnt + 8'd1;

        case (state)
            ST_IDLE: begin
                gnt_en_d   = 1'b0;
                bus_busy_d = 1'b0;
                // A foreign or leftover cycle on the bus blocks any new grant.
                if (any_req && bus_idle) begin
                    gnt_idx_d = winner;
                    tcnt_d    = 8'd0;
                    gnt_en_d  = 1'b1;
                    state_d   = ST_GRANT;
                end
            end

            ST_GRANT: begin
                // FRAME# takes priority over a same-cycle withdraw or timeout.
                if (!frame_n) begin
                    bus_owner_d = gnt_idx;
                    bus_busy_d  = 1'b1;
                    state_d     = ST_BUSY;
                end else if (req_n[gnt_idx]) begin
                    gnt_en_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (tcnt == TCNT_LAST) begin
                    gnt_en_d = 1'b0;
                    ptr_d    = gnt_idx + 2'd1;
                    state_d  = ST_IDLE;
                end
            end

            ST_BUSY: begin
                if (bus_idle) begin
                    gnt_en_d   = 1'b0;
                    bus_busy_d = 1'b0;
                    ptr_d      = bus_owner + 2'd1;
                    state_d    = ST_TURN;
                end else if (req_n[bus_owner]) begin
                    // Once dropped the grant is never re-raised in this BUSY,
                    // because gnt_en_d only ever follows gnt_en downward here.
                    gnt_en_d = 1'b0;
                end
            end

            ST_TURN: begin
                gnt_en_d   = 1'b0;
                bus_busy_d = 1'b0;
                state_d    = ST_IDLE;
            end

            default: begin
                gnt_en_d   = 1'b0;
                bus_busy_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= 2'd0;
            tcnt      <= 8'd0;
            gnt_idx   <= 2'd0;
            gnt_en    <= 1'b0;
            gnt_kill  <= 1'b1;
            bus_busy  <= 1'b0;
            bus_owner <= 2'd0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            tcnt      <= tcnt_d;
            gnt_idx   <= gnt_idx_d;
            gnt_en    <= gnt_en_d;
            // Kill is registered from the same next value as enable so the
            // two can never disagree for even one cycle.
            gnt_kill  <= ~gnt_en_d;
            bus_busy  <= bus_busy_d;
            bus_owner <= bus_owner_d;
        end
    end

endmodule
